// File: rtl/hwag_ign_channel.sv
// Single ignition coil channel: angle-triggered charge/spark FSM with shadow-buffered
// angles and a dwell guard. Define HWAG_IGN_LAST_DWELL_EN to add the last_dwell output.
module hwag_ign_channel #(
    parameter int AW = 24,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hwag_start,
    input  logic [AW-1:0] acnt,
    input  logic [AW-1:0] acnt_max,
    input  logic [AW-1:0] set_angle,
    input  logic [AW-1:0] rst_angle,
    input  logic          load,
    input  logic          upd,
    input  logic [DW-1:0] dwell_max,
    output logic          ign_out,
    output logic          spark,
    output logic          fault_dwell,
    output logic          busy
`ifdef HWAG_IGN_LAST_DWELL_EN
    ,
    output logic [DW-1:0] last_dwell
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SET = 2'd1,
        CHARGE   = 2'd2,
        LOCKOUT  = 2'd3
    } state_e;

    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        logic [DW-1:0] one;
        one = {{(DW-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    state_e        state_q;
    logic          ign_q;
    logic          spark_q;
    logic          fault_q;
    logic          busy_q;
    logic [DW-1:0] dwell_cnt_q;

    logic [AW-1:0] set_sh_q,  set_sh_d;
    logic [AW-1:0] rst_sh_q,  rst_sh_d;
    logic [AW-1:0] set_act_q, set_act_d;
    logic [AW-1:0] rst_act_q, rst_act_d;
    logic          pend_q,    pend_d;
    logic          defer_q,   defer_d;

    logic          set_hit;
    logic          rst_hit;
    logic          dwell_hit;
    logic          leave_charge;
    logic          commit_req;
    logic          commit_now;
    logic [DW-1:0] dwell_inc;

    // An active angle beyond the counter top can never be reached, so it is masked out.
    assign set_hit   = (acnt == set_act_q) && (set_act_q <= acnt_max);
    assign rst_hit   = (acnt == rst_act_q) && (rst_act_q <= acnt_max);
    assign dwell_inc = sat_inc(dwell_cnt_q);
    assign dwell_hit = (dwell_max != '0) && (dwell_inc == dwell_max);

    assign leave_charge = (state_q == CHARGE) && (!hwag_start || rst_hit || dwell_hit);
    assign commit_req   = (upd && pend_q) || defer_q;
    assign commit_now   = commit_req && ((state_q != CHARGE) || leave_charge);

    // A commit always takes the shadow as it stood before this edge's load.
    always_comb begin
        set_sh_d  = set_sh_q;
        rst_sh_d  = rst_sh_q;
        set_act_d = set_act_q;
        rst_act_d = rst_act_q;
        pend_d    = pend_q;
        defer_d   = commit_req && !commit_now;
        if (load) begin
            set_sh_d = set_angle;
            rst_sh_d = rst_angle;
            pend_d   = 1'b1;
        end
        if (commit_now) begin
            set_act_d = set_sh_q;
            rst_act_d = rst_sh_q;
            pend_d    = load;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_sh_q  <= '0;
            rst_sh_q  <= '0;
            set_act_q <= '0;
            rst_act_q <= '0;
            pend_q    <= 1'b0;
            defer_q   <= 1'b0;
        end else begin
            set_sh_q  <= set_sh_d;
            rst_sh_q  <= rst_sh_d;
            set_act_q <= set_act_d;
            rst_act_q <= rst_act_d;
            pend_q    <= pend_d;
            defer_q   <= defer_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ign_q       <= 1'b0;
            spark_q     <= 1'b0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
            dwell_cnt_q <= '0;
`ifdef HWAG_IGN_LAST_DWELL_EN
            last_dwell  <= '0;
`endif
        end else begin
            spark_q <= 1'b0;
            fault_q <= 1'b0;
            if (!hwag_start) begin
                state_q <= IDLE;
                ign_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= WAIT_SET;
                        ign_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    WAIT_SET: begin
                        if (set_hit && (set_act_q != rst_act_q)) begin
                            state_q     <= CHARGE;
                            ign_q       <= 1'b1;
                            busy_q      <= 1'b1;
                            dwell_cnt_q <= '0;
                        end
                    end
                    CHARGE: begin
                        dwell_cnt_q <= dwell_inc;
                        if (rst_hit) begin
                            state_q    <= WAIT_SET;
                            ign_q      <= 1'b0;
                            busy_q     <= 1'b0;
                            spark_q    <= 1'b1;
`ifdef HWAG_IGN_LAST_DWELL_EN
                            last_dwell <= dwell_inc;
`endif
                        end else if (dwell_hit) begin
                            state_q    <= LOCKOUT;
                            ign_q      <= 1'b0;
                            busy_q     <= 1'b0;
                            fault_q    <= 1'b1;
`ifdef HWAG_IGN_LAST_DWELL_EN
                            last_dwell <= dwell_inc;
`endif
                        end
                    end
                    LOCKOUT: begin
                        // Hold off until the spark angle so a forced spark cannot recharge this window.
                        ign_q <= 1'b0;
                        if (rst_hit) begin
                            state_q <= WAIT_SET;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        ign_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ign_out     = ign_q;
    assign spark       = spark_q;
    assign fault_dwell = fault_q;
    assign busy        = busy_q;

endmodule

// File: doc/hwag_ign_channel.md
Name: hwag_ign_channel

Overview:
- Single ignition output channel, directly downstream of the angle generator.
- Consumes the half-rate angle counter (ACNT2), the generator start flag and the CPU-programmed charge/spark angles; drives one coil output.
- Replaces the test-only set/reset flip-flop with a proper state machine, shadow-buffered angle registers, a dwell-time guard and fault flags.
- Instantiated once per coil in the top level; the shadow registers are written through the same ssram-style load strobes.

Parameters:
- AW, 24, angle counter / angle register width
- DW, 24, dwell counter width (clk cycles)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- hwag_start  in  1  generator synchronised; low = channel disabled
- acnt  in  AW  current angle (ACNT2 output); steps by 0 or +1 per cycle, wraps to 0 after acnt_max
- acnt_max  in  AW  angle counter top (HWAMAXACR)
- set_angle  in  AW  charge-start angle, CPU value
- rst_angle  in  AW  spark angle, CPU value
- load  in  1  one-cycle strobe: latch set_angle/rst_angle into shadow
- upd  in  1  one-cycle commit point (tooth edge): shadow -> active
- dwell_max  in  DW  maximum charge time in clk cycles; 0 = guard disabled
- ign_out  out  1  coil drive, 1 = charging
- spark  out  1  one-cycle pulse at normal spark
- fault_dwell  out  1  one-cycle pulse when dwell guard forced the spark
- busy  out  1  state is CHARGE

Behaviour:
- Reset (rst=0, async) clears: ign_out=0, spark=0, fault_dwell=0, busy=0, shadow=0, active=0, pend=0, dwell_cnt=0, state=IDLE.
- Shadow regs: load=1 captures set_angle/rst_angle on that edge; pend<=1.
- Commit: on upd=1 with pend=1:
  - state != CHARGE: active<=shadow, pend<=0.
  - state == CHARGE: commit deferred; applied in the cycle the channel leaves CHARGE.
  - load and upd in the same cycle: the commit uses the old shadow; the new value stays pending.
- States:
  - IDLE: ign_out=0. hwag_start=1 -> WAIT_SET.
  - WAIT_SET: acnt==set_act and set_act!=rst_act -> CHARGE; ign_out<=1, dwell_cnt<=0.
  - CHARGE: dwell_cnt increments and saturates at all-ones.
    - acnt==rst_act -> WAIT_SET; ign_out<=0; spark pulse.
    - Else, if dwell_max!=0 and dwell_cnt+1==dwell_max -> LOCKOUT; ign_out<=0; fault_dwell pulse.
  - LOCKOUT: ign_out=0. acnt==rst_act -> WAIT_SET. Prevents a second charge in the same cycle window.
- hwag_start=0 in any state -> IDLE next edge; ign_out<=0; no spark/fault pulse; pend kept.
- Latency: all outputs are registered. ign_out changes on the clk edge that samples the matching acnt, i.e. one cycle after acnt presents the value.
- Compares are equality only. acnt never skips values, so no range compare is needed.
- Active angle > acnt_max never matches: the channel idles in WAIT_SET with no output. No fault is raised.
- set_act==rst_act: no charge is ever started.
- Wrap-around: set_act > rst_act is legal. Charging spans the acnt wrap at acnt_max -> 0.
- busy = (state==CHARGE), registered with the state.

Optional Feature:
- HWAG_IGN_LAST_DWELL_EN defined:
  - Adds output port last_dwell [DW].
  - On a spark or fault_dwell edge it captures dwell_cnt+1 (actual charge cycles).
  - Reset value 0; holds between events.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- Reset mid-CHARGE: rst=0 while ign_out=1 -> ign_out=0 immediately (async); state IDLE; after rst=1, no output until hwag_start and a set match.
- Normal cycle: hwag_start=1, active set=100, rst=140, dwell_max=0; acnt ramps 0..359, acnt_max=359 -> ign_out high from the edge sampling acnt=100 to the edge sampling 140; spark pulses once; busy mirrors ign_out.
- Dwell guard: set=10, rst=200, dwell_max=50, acnt advancing every 4 clk -> ign_out high exactly 50 cycles; fault_dwell pulses once; no recharge until acnt passes 200 then returns to 10.
- Wrap charge: set=350, rst=20, acnt_max=359 -> ign_out rises at 350, stays high across 359->0, falls at 20; spark pulses once.
- Deferred commit: load set=50/rst=90 during CHARGE, upd during CHARGE -> current charge ends at the old rst angle; next charge uses 50/90. Also with load+upd in the same cycle -> commit uses the old shadow, and the new value applies at the following upd.
- Disable: hwag_start dropped while charging at acnt=120 -> ign_out=0 next edge, no spark, no fault_dwell; with HWAG_IGN_LAST_DWELL_EN, last_dwell unchanged.
